wave_sample_scheduler: RTL
==========================

# wave_sample_scheduler

Sequencer that paces the triangle/sawtooth/square wave generator top at a programmable sample rate. It issues the generator's next-data request strobe and waits for the valid strobe of the selected waveform. It captures that sample into a single-entry output register with a valid/ready handshake toward the downstream consumer (DAC/serializer). It sits between the wave generator top and the output stage and reports overrun and missed-tick conditions through sticky flags.

## Interface
- N_FRAC, 7, fractional bits of the Q0.N_FRAC samples; sample width is N_FRAC+1
- DIV_W, 8, width of the sample-rate divider
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- enable_i  in  1  run the sample-rate ticker
- div_i  in  DIV_W  tick period minus one (0 = tick every cycle)
- wave_sel_i  in  2  00 sawtooth, 01 triangle, 10 square pulse, 11 reserved (treated as sawtooth)
- clear_flags_i  in  1  clears all sticky flags
- get_next_data_strobe_o  out  1  one-cycle request to the generator
- saw_data_i / tri_data_i / sq_data_i  in  N_FRAC+1 each  generator outputs, signed
- saw_valid_i / tri_valid_i / sq_valid_i  in  1 each  generator valid strobes
- sample_o  out  N_FRAC+1  captured sample, signed
- sample_valid_o  out  1  sample_o holds an unconsumed sample
- sample_ready_i  in  1  consumer accepts sample_o
- busy_o  out  1  FSM not in IDLE
- overrun_o  out  1  sticky; a captured sample was dropped
- missed_tick_o  out  1  sticky; a tick occurred while busy
- timeout_o  out  1  sticky; generator failed to answer (macro only)

## Operation
- Ticker:
  - While enable_i=0, cnt <= div_i and no tick is produced.
  - While enable_i=1, a tick fires when cnt==0 and cnt reloads to div_i; otherwise cnt decrements.
  - The first tick fires in the (div_i+1)-th enabled cycle.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on tick, latch wave_sel_i into sel_q and go to REQ.
  - REQ: get_next_data_strobe_o=1 for exactly this cycle, then go to WAIT.
  - WAIT: watch only the valid strobe chosen by sel_q. When it is seen, capture the matching data and return to IDLE. Strobes of unselected waveforms are ignored.
- Tick in REQ or WAIT: the tick is discarded and missed_tick_o is set. Ticks are never queued.
- enable_i falling during REQ/WAIT: the transaction completes normally; no further ticks follow.
- wave_sel_i changes take effect at the next IDLE->REQ transition only.
- Output register:
  - Capture with sample_valid_o=0, or with sample_valid_o=1 and sample_ready_i=1 in the same cycle: load sample_o and set sample_valid_o=1.
  - Capture with sample_valid_o=1 and sample_ready_i=0: keep the old sample, drop the new one, set overrun_o.
  - Handshake with no capture: sample_valid_o=0; sample_o holds its value.
- Sticky flags:
  - clear_flags_i clears all flags.
  - A set event in the same cycle as clear_flags_i wins, so the flag reads 1.
- Data is passed through unchanged; no arithmetic on samples.

## Timing
- Reset (rst_i=1 at a clock edge) forces all of the following on the next cycle, including mid-transaction:
  - state=IDLE, cnt=0, sel_q=00
  - sample_o=0, sample_valid_o=0, get_next_data_strobe_o=0, busy_o=0
  - all flags 0
- Any pending transaction is abandoned by reset. A late generator strobe after reset is ignored because the FSM is in IDLE.
- Tick in cycle T: get_next_data_strobe_o=1 in T+1, WAIT from T+2.
- Selected valid strobe seen in cycle S (S>=T+2): sample_valid_o=1 and sample_o updated in S+1. State is IDLE in S+1, so a tick in S+1 is accepted.
- A valid strobe arriving in the REQ cycle itself is ignored.
- All outputs are registered. get_next_data_strobe_o has no combinational path from any input.
- Minimum sustainable period: div_i must cover the request round trip plus generator latency. Shorter periods produce missed_tick_o.

## Configuration
- WAVE_SCHED_TIMEOUT_EN defined:
  - A 4-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If 15 WAIT cycles elapse without the selected strobe, the FSM returns to IDLE without capture and timeout_o is set.
  - A strobe in the 15th cycle is still captured.
- WAVE_SCHED_TIMEOUT_EN undefined:
  - No wait counter; WAIT lasts indefinitely.
  - timeout_o is constant 0.

## Test plan
- Reset mid-WAIT: assert rst_i during WAIT, then release -> all outputs 0 the cycle after reset; a later tri_valid_i strobe produces no sample.
- Periodic sawtooth: div_i=9, wave_sel_i=00, generator answers in 1 cycle, sample_ready_i=1 -> get_next_data_strobe_o every 10 cycles, first in the 11th enabled cycle; sample_valid_o 1 cycle after each saw_valid_i with matching sample_o; no flags set.
- Triangle selection: wave_sel_i=01, saw_valid_i at S, tri_valid_i at S+1 with data 0x3A -> sample_o=0x3A at S+2; the saw strobe is ignored.
- Backpressure: sample_ready_i=0 for three periods -> first sample is held, overrun_o=1 from the second capture on; one cycle with clear_flags_i=1 and no capture -> overrun_o=0.
- Missed tick: div_i=0 with a generator latency of 3 -> missed_tick_o=1, and exactly one request per transaction.
- Timeout (macro defined): the generator never answers -> FSM in IDLE after 15 WAIT cycles, timeout_o=1, sample_valid_o stays 0. Macro undefined: busy_o stays 1 and timeout_o=0.

Source files
------------

// File: rtl/wave_sample_scheduler_if.sv
// Sample bus between the wave generator, the scheduler and the downstream consumer.
// master = scheduler side, slave = generator/consumer side.
interface wave_sample_scheduler_if #(
    parameter int N_FRAC = 7
);
    localparam int SW = N_FRAC + 1;

    logic                 get_next_data_strobe_o;
    logic signed [SW-1:0] saw_data_i;
    logic signed [SW-1:0] tri_data_i;
    logic signed [SW-1:0] sq_data_i;
    logic                 saw_valid_i;
    logic                 tri_valid_i;
    logic                 sq_valid_i;
    logic signed [SW-1:0] sample_o;
    logic                 sample_valid_o;
    logic                 sample_ready_i;

    modport master (
        output get_next_data_strobe_o, sample_o, sample_valid_o,
        input  saw_data_i, tri_data_i, sq_data_i,
        input  saw_valid_i, tri_valid_i, sq_valid_i, sample_ready_i
    );

    modport slave (
        input  get_next_data_strobe_o, sample_o, sample_valid_o,
        output saw_data_i, tri_data_i, sq_data_i,
        output saw_valid_i, tri_valid_i, sq_valid_i, sample_ready_i
    );
endinterface

// File: rtl/wave_sample_scheduler.sv
// Paces the wave generator at a programmable rate and captures one sample per tick.
// Optional generator-timeout watchdog enabled by defining WAVE_SCHED_TIMEOUT_EN.
module wave_sample_scheduler #(
    parameter int N_FRAC = 7,
    parameter int DIV_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [1:0]       wave_sel_i,
    input  logic             clear_flags_i,
    wave_sample_scheduler_if.master bus,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             missed_tick_o,
    output logic             timeout_o
);
    localparam int SW = N_FRAC + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [1:0]           sel_idx;
    logic [DIV_W-1:0]     cnt_q;
    logic                 tick;
    logic [2:0][SW-1:0]   wave_data;
    logic [2:0]           wave_vld;
    logic [SW-1:0]        sel_data;
    logic                 sel_vld;
    logic                 wait_expired;

    logic                 capture, load_sample, drop_sample;
    logic                 missed_evt, timeout_evt;
    logic                 strobe_d, busy_d;

    logic                 strobe_q, busy_q;
    logic signed [SW-1:0] sample_q;
    logic                 sample_vld_q;
    logic                 overrun_q, missed_q;

    // Generator channels packed so the selected one is a plain index.
    assign wave_data = {bus.sq_data_i, bus.tri_data_i, bus.saw_data_i};
    assign wave_vld  = {bus.sq_valid_i, bus.tri_valid_i, bus.saw_valid_i};
    assign sel_idx   = (sel_q == 2'b11) ? 2'b00 : sel_q;
    assign sel_data  = wave_data[sel_idx];
    assign sel_vld   = wave_vld[sel_idx];

    // Ticker: preload while disabled so the first tick lands div_i+1 cycles in.
    always_ff @(posedge clk_i) begin
        if (rst_i)               cnt_q <= '0;
        else if (!enable_i)      cnt_q <= div_i;
        else if (cnt_q == '0)    cnt_q <= div_i;
        else                     cnt_q <= cnt_q - 1'b1;
    end

    assign tick = enable_i && (cnt_q == '0);

`ifdef WAVE_SCHED_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                   wait_cnt <= '0;
        else if (state_q == S_REQ)   wait_cnt <= '0;
        else if (state_q == S_WAIT)  wait_cnt <= wait_cnt + 4'd1;
    end

    // Last chance is the 15th WAIT cycle; a strobe there still wins.
    assign wait_expired = (state_q == S_WAIT) && (wait_cnt == 4'd14);

    always_ff @(posedge clk_i) begin
        if (rst_i) timeout_q <= 1'b0;
        else       timeout_q <= timeout_evt | (timeout_q & ~clear_flags_i);
    end

    assign timeout_o = timeout_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_REQ;
                    sel_d   = wave_sel_i;
                end
            end
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (sel_vld || wait_expired) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; everything here feeds a register below.
    always_comb begin
        capture     = (state_q == S_WAIT) && sel_vld;
        load_sample = capture && (!sample_vld_q || bus.sample_ready_i);
        drop_sample = capture && sample_vld_q && !bus.sample_ready_i;
        missed_evt  = tick && (state_q != S_IDLE);
        timeout_evt = wait_expired && !sel_vld;
        strobe_d    = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    // Single-entry output register; a capture in the same cycle as a pop refills it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else if (load_sample) begin
            sample_q     <= sel_data;
            sample_vld_q <= 1'b1;
        end else if (sample_vld_q && bus.sample_ready_i) begin
            sample_vld_q <= 1'b0;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            overrun_q <= drop_sample | (overrun_q & ~clear_flags_i);
            missed_q  <= missed_evt  | (missed_q  & ~clear_flags_i);
        end
    end

    assign bus.get_next_data_strobe_o = strobe_q;
    assign bus.sample_o               = sample_q;
    assign bus.sample_valid_o         = sample_vld_q;
    assign busy_o                     = busy_q;
    assign overrun_o                  = overrun_q;
    assign missed_tick_o              = missed_q;
endmodule
